// File: rtl/slow_io_pkg.sv
// Shared slow-I/O types: channel count, sample width, scheduler states, sign flip.
// Also used by the slow-ADC input path.
package slow_io_pkg;

    localparam int NCH = 16;
    localparam int W   = 16;
    localparam int CHW = $clog2(NCH);

    typedef logic [CHW-1:0]      ch_idx_t;
    typedef logic signed [W-1:0] sample_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    // Inverting amplifier: -x-1, so the full range maps onto itself without saturation.
    function automatic sample_t sgn_flip(input sample_t x);
        return ~x;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set bit of req at or after ptr, wrapping circularly.
// Purely combinational, no backpressure.
module rr_pick
    import slow_io_pkg::*;
(
    input  logic [NCH-1:0] req,
    input  ch_idx_t        ptr,
    output logic           found,
    output ch_idx_t        idx
);

    int j;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int i = 0; i < NCH; i++) begin
            j = int'(ptr) + i;
            if (j >= NCH) begin
                j = j - NCH;
            end
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = ch_idx_t'(j);
            end
        end
    end

endmodule

// File: rtl/slow_dac_scheduler.sv
// Round-robin scheduler sharing one slow-DAC driver among NCH outputs; sends changed channels sign-flipped.
// Latency: dirty -> dac_req one edge later; one idle cycle between words. Word held until dac_ack or timeout.
// Optional SLOW_DAC_REFRESH_EN: periodic forced re-send of all enabled channels after REFRESH_CYC idle cycles.
module slow_dac_scheduler
    import slow_io_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1023,
    parameter int REFRESH_CYC = 1000000
) (
    input  logic             sDAC_clk,
    input  logic             rst,
    input  logic [NCH*W-1:0] sout_flat,
    input  logic [NCH-1:0]   ch_en,
    output logic             dac_req,
    output logic [CHW-1:0]   dac_ch,
    output logic [W-1:0]     dac_data,
    input  logic             dac_ack,
    output logic             busy,
    output logic             err_timeout,
    input  logic             clr_err
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    state_t          state_q, state_d;
    ch_idx_t         ptr_q, ptr_d;
    ch_idx_t         ch_q, ch_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [W-1:0]    data_q, data_d;
    logic            err_q, err_d;
    logic [W-1:0]    last_q [NCH];
    logic [W-1:0]    last_d [NCH];
    logic [NCH-1:0]  force_q, force_d;

    logic [W-1:0]    sout_arr [NCH];
    logic [NCH-1:0]  dirty;
    logic            pick_found;
    ch_idx_t         pick_idx;
    logic            ack_done;
    logic            tmo;
    ch_idx_t         nxt_ptr;
    logic            refresh_hit;

    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            sout_arr[k] = sout_flat[k*W +: W];
            dirty[k]    = ch_en[k] & (force_q[k] | (sout_arr[k] != last_q[k]));
        end
    end

    rr_pick u_pick (
        .req   (dirty),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign ack_done = (state_q == REQ) && dac_ack;
    assign tmo      = (state_q == REQ) && !dac_ack && (timer_q == TW'(ACK_TIMEOUT));
    assign nxt_ptr  = (ch_q == ch_idx_t'(NCH - 1)) ? '0 : ch_q + ch_idx_t'(1);

`ifdef SLOW_DAC_REFRESH_EN
    localparam int RW = $clog2(REFRESH_CYC + 1);

    logic [RW-1:0] refresh_q, refresh_d;

    assign refresh_hit = (state_q == IDLE) && !pick_found && (refresh_q == RW'(REFRESH_CYC - 1));

    // Counts only quiet idle cycles; any transaction restarts the interval.
    always_comb begin
        refresh_d = '0;
        if ((state_q == IDLE) && !pick_found && !refresh_hit) begin
            refresh_d = refresh_q + RW'(1);
        end
    end

    always_ff @(posedge sDAC_clk or posedge rst) begin
        if (rst) begin
            refresh_q <= '0;
        end else begin
            refresh_q <= refresh_d;
        end
    end
`else
    assign refresh_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge sDAC_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_found)       state_d = REQ;
            REQ:     if (ack_done || tmo)  state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        dac_req     = (state_q == REQ);
        busy        = (state_q != IDLE);
        dac_ch      = ch_q;
        dac_data    = data_q;
        err_timeout = err_q;
    end

    // Datapath: word latch, bookkeeping per channel, timer and sticky error.
    always_comb begin
        ptr_d   = ptr_q;
        ch_d    = ch_q;
        timer_d = timer_q;
        data_d  = data_q;
        err_d   = err_q;
        last_d  = last_q;
        force_d = force_q;

        if (refresh_hit) begin
            force_d = '1;
        end

        if ((state_q == IDLE) && pick_found) begin
            ch_d    = pick_idx;
            data_d  = sgn_flip(sample_t'(sout_arr[pick_idx]));
            timer_d = '0;
        end

        if (ack_done) begin
            // Flip is its own inverse, so the snapshot is recovered from the held word.
            last_d[ch_q]  = sgn_flip(sample_t'(data_q));
            force_d[ch_q] = 1'b0;
            ptr_d         = nxt_ptr;
        end else if (tmo) begin
            ptr_d = nxt_ptr;
        end else if (state_q == REQ) begin
            timer_d = timer_q + TW'(1);
        end

        if (clr_err) begin
            err_d = 1'b0;
        end
        if (tmo) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge sDAC_clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            ch_q    <= '0;
            timer_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            force_q <= '1;
            for (int k = 0; k < NCH; k++) begin
                last_q[k] <= '0;
            end
        end else begin
            ptr_q   <= ptr_d;
            ch_q    <= ch_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            err_q   <= err_d;
            force_q <= force_d;
            for (int k = 0; k < NCH; k++) begin
                last_q[k] <= last_d[k];
            end
        end
    end

endmodule

// File: tb/tb_slow_dac_scheduler.sv
// Scoreboarded bench for slow_dac_scheduler: behavioural model predicts each word, monitor checks DUT words.
module tb_slow_dac_scheduler;
    import slow_io_pkg::*;

    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NCH*W-1:0] sout_flat = '0;
    logic [NCH-1:0]   ch_en = '1;
    logic             dac_req;
    logic [CHW-1:0]   dac_ch;
    logic [W-1:0]     dac_data;
    logic             dac_ack = 1'b0;
    logic             busy;
    logic             err_timeout;
    logic             clr_err = 1'b0;

    slow_dac_scheduler #(.ACK_TIMEOUT(TO)) dut (
        .sDAC_clk    (clk),
        .rst         (rst),
        .sout_flat   (sout_flat),
        .ch_en       (ch_en),
        .dac_req     (dac_req),
        .dac_ch      (dac_ch),
        .dac_data    (dac_data),
        .dac_ack     (dac_ack),
        .busy        (busy),
        .err_timeout (err_timeout),
        .clr_err     (clr_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] m_flip(input logic [15:0] x);
        int v;
        v = -int'($signed(x)) - 1;
        return v[15:0];
    endfunction

    typedef struct {
        int          ch;
        logic [15:0] dat;
    } word_t;

    word_t exp_q[$];

    // Reference model: transaction-level view of the scheduling rules.
    bit          m_busy = 0;
    bit          m_err = 0;
    int          m_ptr = 0;
    int          m_k = 0;
    int          m_timer = 0;
    logic [15:0] m_snap = '0;
    logic [15:0] m_last [NCH];
    bit          m_force [NCH];

    always @(posedge clk or posedge rst) begin
        bit setr;
        bit got;
        int k;
        setr = 0;
        got  = 0;
        k    = 0;
        if (rst) begin
            m_busy = 0;
            m_err  = 0;
            m_ptr  = 0;
            for (int i = 0; i < NCH; i++) begin
                m_last[i]  = '0;
                m_force[i] = 1;
            end
        end else begin
            if (m_busy) begin
                if (dac_ack) begin
                    m_last[m_k]  = m_snap;
                    m_force[m_k] = 0;
                    m_ptr        = (m_k + 1) % NCH;
                    m_busy       = 0;
                end else if (m_timer == TO) begin
                    setr   = 1;
                    m_ptr  = (m_k + 1) % NCH;
                    m_busy = 0;
                end else begin
                    m_timer++;
                end
            end else begin
                for (int i = 0; i < NCH; i++) begin
                    k = (m_ptr + i) % NCH;
                    if (!got && ch_en[k] && (m_force[k] || sout_flat[k*W +: W] != m_last[k])) begin
                        got     = 1;
                        m_busy  = 1;
                        m_k     = k;
                        m_snap  = sout_flat[k*W +: W];
                        m_timer = 0;
                        exp_q.push_back('{ch: k, dat: m_flip(m_snap)});
                    end
                end
            end
            if (clr_err) m_err = 0;
            if (setr)    m_err = 1;
        end
    end

    // Monitor: pops expected words as the DUT presents them and checks per-cycle status.
    bit          prev_req = 0;
    word_t       cur;
    int          hi_cnt = 0;
    int          log_ch[$];
    logic [15:0] log_dat[$];
    int          log_dur[$];

    always @(posedge clk) begin
        #1;
        chk("dac_req_vs_model", 32'(dac_req), 32'(m_busy));
        chk("busy_vs_model", 32'(busy), 32'(m_busy));
        chk("err_vs_model", 32'(err_timeout), 32'(m_err));
        if (dac_req && !prev_req) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_word: got ch=%0d data=%0h expected no word", dac_ch, dac_data);
                cur = '{ch: int'(dac_ch), dat: dac_data};
            end else begin
                cur = exp_q.pop_front();
                chk("word_ch", 32'(dac_ch), 32'(cur.ch));
                chk("word_data", 32'(dac_data), 32'(cur.dat));
            end
            log_ch.push_back(int'(dac_ch));
            log_dat.push_back(dac_data);
            hi_cnt = 1;
        end else if (dac_req) begin
            chk("ch_frozen", 32'(dac_ch), 32'(cur.ch));
            chk("data_frozen", 32'(dac_data), 32'(cur.dat));
            hi_cnt++;
        end else if (prev_req) begin
            log_dur.push_back(hi_cnt);
        end
        prev_req = dac_req;
    end

    // Driver-side responder: ack on the second req cycle unless the channel is blocked.
    int acnt = 0;
    bit noack [NCH];
    bit stray = 0;

    always @(negedge clk) begin
        if (dac_req && !rst) begin
            acnt++;
            dac_ack = (acnt == 2) && !noack[dac_ch];
        end else begin
            acnt    = 0;
            dac_ack = stray;
        end
    end

    task automatic set_ch(input int k, input logic [15:0] v);
        sout_flat[k*W +: W] = v;
    endtask

    task automatic wait_quiet();
        int quiet;
        int cyc;
        quiet = 0;
        cyc   = 0;
        while (quiet < 6 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (!dac_req && !busy) quiet++;
            else quiet = 0;
        end
        if (quiet < 6) begin
            n_chk++;
            n_err++;
            $display("FAIL drain_timeout: got busy after %0d cycles expected idle", cyc);
        end
    endtask

    task automatic wait_req_ch(input int ch);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(dac_req && (ch < 0 || int'(dac_ch) == ch)) && c < 500);
        if (!(dac_req && (ch < 0 || int'(dac_ch) == ch))) begin
            n_chk++;
            n_err++;
            $display("FAIL wait_req: got no req for ch=%0d expected req", ch);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int b;
        int db;
        int idx;
        for (int i = 0; i < NCH; i++) noack[i] = 0;
        #1 rst = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_dac_req", 32'(dac_req), 0);
        chk("rst_dac_ch", 32'(dac_ch), 0);
        chk("rst_dac_data", 32'(dac_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_err", 32'(err_timeout), 0);

        // All-zero inputs after reset: forced burst 0..15 of 0xFFFF
        b = log_ch.size();
        rst = 1'b0;
        wait_quiet();
        chk("t1_count", 32'(log_ch.size() - b), 16);
        for (int i = 0; i < 16; i++) begin
            if (b + i < log_ch.size()) begin
                chk("t1_order", 32'(log_ch[b+i]), 32'(i));
                chk("t1_data", 32'(log_dat[b+i]), 32'h0000FFFF);
            end
        end
        chk("t1_busy_end", 32'(busy), 0);

        // Move pointer to 5, then make ch3 and ch9 dirty together: extreme values
        set_ch(4, 16'd1234);
        wait_quiet();
        b = log_ch.size();
        set_ch(3, 16'h8000);
        set_ch(9, 16'h7FFF);
        wait_quiet();
        chk("t2_count", 32'(log_ch.size() - b), 2);
        if (log_ch.size() >= b + 2) begin
            chk("t2_first_ch", 32'(log_ch[b]), 9);
            chk("t2_first_data", 32'(log_dat[b]), 32'h00008000);
            chk("t2_second_ch", 32'(log_ch[b+1]), 3);
            chk("t2_second_data", 32'(log_dat[b+1]), 32'h00007FFF);
        end

        // Input change during REQ: snapshot sent, then new value re-sent
        b = log_ch.size();
        set_ch(2, 16'd100);
        wait_req_ch(2);
        chk("t3_held_data", 32'(dac_data), 32'h0000FF9B);
        set_ch(2, 16'd200);
        wait_quiet();
        chk("t3_count", 32'(log_ch.size() - b), 2);
        if (log_ch.size() >= b + 2) begin
            chk("t3_first", 32'({log_ch[b][15:0], log_dat[b]}), 32'h0002FF9B);
            chk("t3_second", 32'({log_ch[b+1][15:0], log_dat[b+1]}), 32'h0002FF37);
        end

        // Timeout on ch7, retried after the other dirty channels; sticky error then clear
        noack[7] = 1;
        b  = log_ch.size();
        db = log_dur.size();
        set_ch(7, 16'd5);
        set_ch(1, 16'd11);
        set_ch(10, 16'd12);
        wait_req_ch(7);
        idx = 0;
        while (dac_req && idx < 50) begin
            @(negedge clk);
            idx++;
        end
        noack[7] = 0;
        chk("t4_err_set", 32'(err_timeout), 1);
        wait_quiet();
        chk("t4_count", 32'(log_ch.size() - b), 4);
        if (log_ch.size() >= b + 4) begin
            chk("t4_order0", 32'(log_ch[b]), 7);
            chk("t4_order1", 32'(log_ch[b+1]), 10);
            chk("t4_order2", 32'(log_ch[b+2]), 1);
            chk("t4_order3", 32'(log_ch[b+3]), 7);
        end
        if (log_dur.size() > db) chk("t4_req_cycles", 32'(log_dur[db]), 32'(TO + 1));
        chk("t4_err_sticky", 32'(err_timeout), 1);
        @(negedge clk) clr_err = 1'b1;
        @(negedge clk) clr_err = 1'b0;
        chk("t4_err_cleared", 32'(err_timeout), 0);

        // Reset mid-transaction, ch6 disabled: re-send of enabled channels from ch0
        ch_en[6] = 1'b0;
        set_ch(5, 16'd77);
        wait_req_ch(-1);
        rst = 1'b1;
        #1;
        chk("t5_req_drop", 32'(dac_req), 0);
        chk("t5_busy_drop", 32'(busy), 0);
        chk("t5_data_rst", 32'(dac_data), 0);
        b = log_ch.size();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_quiet();
        chk("t5_count", 32'(log_ch.size() - b), 15);
        idx = 0;
        for (int k = 0; k < NCH; k++) begin
            if (k != 6 && b + idx < log_ch.size()) begin
                chk("t5_order", 32'(log_ch[b+idx]), 32'(k));
                chk("t5_data", 32'(log_dat[b+idx]), 32'(m_flip(sout_flat[k*W +: W])));
                idx++;
            end
        end
        ch_en[6] = 1'b1;
        wait_quiet();

        // Static inputs: no traffic; a stray ack while idle is ignored
        b = log_ch.size();
        @(negedge clk) stray = 1;
        repeat (2) @(negedge clk);
        stray = 0;
        repeat (200) @(negedge clk);
        chk("t6_no_traffic", 32'(log_ch.size() - b), 0);

        // Randomized traffic against the model
        b = log_ch.size();
        repeat (800) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) set_ch($urandom_range(0, NCH - 1), 16'($urandom));
            if ($urandom_range(0, 40) == 0) ch_en[$urandom_range(0, NCH - 1)] ^= 1'b1;
        end
        ch_en = '1;
        wait_quiet();
        chk("rand_pending", 32'(exp_q.size()), 0);
        chk("rand_busy_end", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
